// File: rtl/bitwise_share_arbiter.sv
// bitwise_share_arbiter: one shared XOR unit (lhs ^ rhs) time-multiplexed among
// NUM_REQ valid/ready requesters, each owning a one-entry result slot.
// Default build arbitrates round-robin. Defining BITWISE_SHARE_FIXED_PRIO_EN
// removes the rotating pointer so the lowest eligible index always wins.
module bitwise_share_arbiter #(
    parameter int DATA_TYPE = 32,
    parameter int NUM_REQ   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*DATA_TYPE-1:0] lhs,
    input  logic [NUM_REQ-1:0]           lhs_valid,
    input  logic [NUM_REQ*DATA_TYPE-1:0] rhs,
    input  logic [NUM_REQ-1:0]           rhs_valid,
    input  logic [NUM_REQ-1:0]           result_ready,
    output logic [NUM_REQ*DATA_TYPE-1:0] result,
    output logic [NUM_REQ-1:0]           result_valid,
    output logic [NUM_REQ-1:0]           lhs_ready,
    output logic [NUM_REQ-1:0]           rhs_ready
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                full;
    logic [NUM_REQ-1:0][DATA_TYPE-1:0] slot;
    logic [NUM_REQ-1:0]                eligible;
    logic [NUM_REQ-1:0]                rotated;
    logic [PTR_W-1:0]                  scan_start;
    logic                              grant_found;
    int                                grant_offset;
    int                                grant_sum;
    logic [PTR_W-1:0]                  grant_idx;
    logic [NUM_REQ-1:0]                grant_vec;

`ifndef BITWISE_SHARE_FIXED_PRIO_EN
    logic [PTR_W-1:0] ptr;
`endif

    // A requester may fire only with both operands present and room in its slot
    // (a full slot counts as room when it is being drained this same cycle).
    always_comb begin
        eligible = lhs_valid & rhs_valid & (~full | result_ready);
    end

`ifdef BITWISE_SHARE_FIXED_PRIO_EN
    // Fixed priority: the scan always begins at requester 0.
    always_comb begin
        scan_start = '0;
        rotated    = eligible;
    end
`else
    // Round-robin: rotate the eligible vector so bit 0 corresponds to ptr.
    always_comb begin
        scan_start = ptr;
        rotated    = NUM_REQ'({eligible, eligible} >> ptr);
    end
`endif

    // Pick the first eligible requester in scan order and map it back to its index.
    always_comb begin
        grant_found  = 1'b0;
        grant_offset = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                grant_found  = 1'b1;
                grant_offset = k;
            end
        end
        grant_sum = grant_offset + int'(scan_start);
        if (grant_sum >= NUM_REQ) begin
            grant_sum = grant_sum - NUM_REQ;
        end
        grant_idx = PTR_W'(grant_sum);
        grant_vec = '0;
        if (grant_found && !rst) begin
            grant_vec = NUM_REQ'(1) << grant_idx;
        end
    end

    assign lhs_ready    = grant_vec;
    assign rhs_ready    = grant_vec;
    assign result_valid = full;
    assign result       = slot;

    // Slot occupancy: a grant fills the slot, a handshake without a refill empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            full <= grant_vec | (full & ~result_ready);
        end
    end

`ifndef BITWISE_SHARE_FIXED_PRIO_EN
    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_found) begin
            if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + PTR_W'(1);
            end
        end
    end
`endif

    // Capture the shared XOR result into the granted requester's slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i]) begin
                slot[i] <= lhs[i*DATA_TYPE +: DATA_TYPE] ^ rhs[i*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

endmodule

// File: tb/tb_bitwise_share_arbiter.sv
// tb_bitwise_share_arbiter: directed and random checks of the shared XOR
// arbiter (NUM_REQ=4, DATA_TYPE=32) against a slot-level behavioural model.
module tb_bitwise_share_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] lhs;
    logic [N-1:0]   lhs_valid;
    logic [N*W-1:0] rhs;
    logic [N-1:0]   rhs_valid;
    logic [N-1:0]   result_ready;
    logic [N*W-1:0] result;
    logic [N-1:0]   result_valid;
    logic [N-1:0]   lhs_ready;
    logic [N-1:0]   rhs_ready;

    int total = 0;
    int bad   = 0;

    // behavioural model: which slots hold a result, what they hold, where the scan starts
    int          m_ptr = 0;
    bit          m_full [N];
    logic [W-1:0] m_data [N];

    logic [N-1:0]   obs_ready;
    logic [N-1:0]   obs_valid;
    logic [N*W-1:0] obs_result;

    bitwise_share_arbiter #(.DATA_TYPE(W), .NUM_REQ(N)) dut (
        .clk(clk),
        .rst(rst),
        .lhs(lhs),
        .lhs_valid(lhs_valid),
        .rhs(rhs),
        .rhs_valid(rhs_valid),
        .result_ready(result_ready),
        .result(result),
        .result_valid(result_valid),
        .lhs_ready(lhs_ready),
        .rhs_ready(rhs_ready)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [N-1:0] lv, input logic [N-1:0] rv,
                                  input logic [N-1:0] rr);
        rst          = r;
        lhs_valid    = lv;
        rhs_valid    = rv;
        result_ready = rr;
        lhs = {$urandom, $urandom, $urandom, $urandom};
        rhs = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Sample mid-cycle, compare against the model, then step the model across the edge.
    task automatic check_output(input string tag);
        int             exp_g;
        int             idx;
        logic [N-1:0]   exp_ready;
        logic [N-1:0]   exp_valid;
        #4;
        exp_g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (exp_g < 0 && lhs_valid[idx] && rhs_valid[idx] &&
                    (!m_full[idx] || result_ready[idx])) begin
                    exp_g = idx;
                end
            end
        end
        exp_ready = (exp_g >= 0) ? N'(1 << exp_g) : '0;
        for (int i = 0; i < N; i++) exp_valid[i] = m_full[i];
        obs_ready  = lhs_ready;
        obs_valid  = result_valid;
        obs_result = result;
        expect_eq({tag, ".lhs_ready"}, (N*W)'(lhs_ready), (N*W)'(exp_ready));
        expect_eq({tag, ".rhs_ready"}, (N*W)'(rhs_ready), (N*W)'(exp_ready));
        expect_eq({tag, ".result_valid"}, (N*W)'(result_valid), (N*W)'(exp_valid));
        for (int i = 0; i < N; i++) begin
            if (m_full[i]) begin
                expect_eq($sformatf("%s.result%0d", tag, i), (N*W)'(result[i*W +: W]), (N*W)'(m_data[i]));
            end
        end
        @(posedge clk);
        if (rst) begin
            m_ptr = 0;
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (result_ready[i]) m_full[i] = 1'b0;
            end
            if (exp_g >= 0) begin
                m_data[exp_g] = lhs[exp_g*W +: W] ^ rhs[exp_g*W +: W];
                m_full[exp_g] = 1'b1;
`ifndef BITWISE_SHARE_FIXED_PRIO_EN
                m_ptr = (exp_g + 1) % N;
`endif
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
        end
        apply_stimulus(1'b1, '1, '1, '1);
        @(posedge clk);
        #1;

        // reset held with every requester valid: nothing accepted, nothing valid
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b1, '1, '1, '1);
            check_output("reset");
            expect_eq("reset.ready_zero", (N*W)'(obs_ready), '0);
            expect_eq("reset.valid_zero", (N*W)'(obs_valid), '0);
        end

        // full contention: round-robin 0,1,2,3,... (fixed priority: always 0)
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(1'b0, '1, '1, '1);
            check_output("contend");
`ifdef BITWISE_SHARE_FIXED_PRIO_EN
            expect_eq("contend.order", (N*W)'(obs_ready), (N*W)'(4'b0001));
`else
            expect_eq("contend.order", (N*W)'(obs_ready), (N*W)'(1 << (c % N)));
`endif
        end

        // lone requester 1 streaming a fixed operand pair
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b0, 4'b0010, 4'b0010, '1);
            lhs[1*W +: W] = 32'hFFFF0000;
            rhs[1*W +: W] = 32'h0F0F0F0F;
            check_output("single");
            expect_eq("single.accept", (N*W)'(obs_ready), (N*W)'(4'b0010));
            if (c >= 1) begin
                expect_eq("single.result1", (N*W)'(obs_result[1*W +: W]), (N*W)'(32'hF0F00F0F));
                expect_eq("single.valid1", (N*W)'(obs_valid[1]), (N*W)'(1'b1));
            end
        end

        // backpressure: fill slot 0, stall it, requester 1 keeps flowing
        apply_stimulus(1'b0, 4'b0001, 4'b0001, 4'b0000);
        check_output("bp_fill");
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(1'b0, 4'b0011, 4'b0011, 4'b1110);
            check_output("bp_stall");
            expect_eq("bp_stall.only_req1", (N*W)'(obs_ready), (N*W)'(4'b0010));
        end
        apply_stimulus(1'b0, 4'b0011, 4'b0011, 4'b1111);
        check_output("bp_release");
        expect_eq("bp_release.req0", (N*W)'(obs_ready), (N*W)'(4'b0001));
        apply_stimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
        check_output("bp_after");
        expect_eq("bp_after.valid", (N*W)'(obs_valid), (N*W)'(4'b0001));

        // join: a lone left operand is never consumed
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(1'b0, 4'b0100, 4'b0000, 4'b1111);
            check_output("join_wait");
            expect_eq("join_wait.no_ready", (N*W)'(obs_ready), '0);
        end
        apply_stimulus(1'b0, 4'b0100, 4'b0100, 4'b1111);
        check_output("join_fire");
        expect_eq("join_fire.both", (N*W)'(obs_ready), (N*W)'(4'b0100));

        // random traffic with occasional resets
        for (int c = 0; c < 300; c++) begin
            apply_stimulus(($urandom_range(0, 39) == 0), N'($urandom), N'($urandom), N'($urandom));
            check_output("random");
        end

        // mid-operation reset with slots 0,1,3 full
        apply_stimulus(1'b0, 4'b0000, 4'b0000, 4'b1111);
        check_output("mid_drain");
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b0, 4'b1011, 4'b1011, 4'b0000);
            check_output("mid_fill");
        end
        expect_eq("mid_fill.valid", (N*W)'(obs_valid), (N*W)'(4'b1011));
        apply_stimulus(1'b1, 4'b1111, 4'b1111, 4'b0000);
        check_output("mid_reset");
        apply_stimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
        check_output("mid_after");
        expect_eq("mid_after.valid", (N*W)'(obs_valid), '0);
        apply_stimulus(1'b0, 4'b1111, 4'b1111, 4'b1111);
        check_output("mid_first");
        expect_eq("mid_first.req0", (N*W)'(obs_ready), (N*W)'(4'b0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
